// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed, active-low 4-digit 7-segment drive.
// Each settled digit is decoded back to BCD and a full frame is published once all four positions are seen.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  led_bit,
  input  logic [7:0]  led_out,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        seg_err,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [11:0]   sync1_reg, sync2_reg, prev_reg;
  logic [SW-1:0] stab_cnt_reg, stab_cnt_next;
  logic [TW-1:0] to_cnt_reg;
  logic [3:0]    seen_mask_reg;
  logic [15:0]   digit_reg;
  logic [3:0]    dp_reg;
  logic [19:0]   last_frame_reg;

  logic          sel_valid;
  logic [1:0]    sel_idx;
  logic [3:0]    sel_onehot;
  logic [3:0]    seg_val;
  logic          seg_legal;
  logic          s_changed;
  logic          capture, legal_cap, publish, timeout_hit;
  logic [15:0]   digit_merge;
  logic [3:0]    dp_merge;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      state_reg    <= IDLE;
      stab_cnt_reg <= '0;
    end else begin
      sync1_reg    <= {led_bit, led_out};
      sync2_reg    <= sync1_reg;
      prev_reg     <= sync2_reg;
      state_reg    <= state_next;
      stab_cnt_reg <= stab_cnt_next;
    end
  end

  assign s_changed  = (sync2_reg != prev_reg);
  assign sel_onehot = 4'b0001 << sel_idx;

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (sync2_reg[11:8])
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  // Segment bus is active-low with bit6 = g ... bit0 = a.
  always_comb begin
    seg_legal = 1'b1;
    seg_val   = 4'd0;
    case (sync2_reg[6:0])
      7'h40:   seg_val = 4'd0;
      7'h79:   seg_val = 4'd1;
      7'h24:   seg_val = 4'd2;
      7'h30:   seg_val = 4'd3;
      7'h19:   seg_val = 4'd4;
      7'h12:   seg_val = 4'd5;
      7'h02:   seg_val = 4'd6;
      7'h78:   seg_val = 4'd7;
      7'h00:   seg_val = 4'd8;
      7'h10:   seg_val = 4'd9;
      default: seg_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    stab_cnt_next = stab_cnt_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          state_next    = SETTLE;
          stab_cnt_next = SW'(1);
        end
      end
      SETTLE, HOLD: begin
        if (!sel_valid) begin
          state_next    = IDLE;
          stab_cnt_next = '0;
        end else if (s_changed) begin
          state_next    = SETTLE;
          stab_cnt_next = SW'(1);
        end else if (state_reg == SETTLE) begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
          if (stab_cnt_next == STAB_LAST) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign legal_cap   = capture & seg_legal;
  assign seg_err     = capture & ~seg_legal;
  assign publish     = legal_cap && ((seen_mask_reg | sel_onehot) == 4'hF);
  assign timeout_hit = !capture && (to_cnt_reg == TO_LAST - 1'b1);

  // Merge the current capture so a completing digit is published without an extra cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign digit_merge[gi*4 +: 4] = (legal_cap && sel_onehot[gi]) ? seg_val : digit_reg[gi*4 +: 4];
    assign dp_merge[gi]           = (legal_cap && sel_onehot[gi]) ? ~sync2_reg[7] : dp_reg[gi];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      digit_reg      <= '0;
      dp_reg         <= '0;
      seen_mask_reg  <= '0;
      last_frame_reg <= '0;
      to_cnt_reg     <= '0;
      stale          <= 1'b0;
      digits         <= '0;
      dp             <= '0;
      frame_valid    <= 1'b0;
      value_changed  <= 1'b0;
    end else begin
      digit_reg     <= digit_merge;
      dp_reg        <= dp_merge;
      frame_valid   <= publish;
      value_changed <= publish && ({digit_merge, dp_merge} != last_frame_reg);
      if (publish) begin
        digits         <= digit_merge;
        dp             <= dp_merge;
        last_frame_reg <= {digit_merge, dp_merge};
        seen_mask_reg  <= '0;
      end else if (legal_cap) begin
        seen_mask_reg  <= seen_mask_reg | sel_onehot;
      end else if (timeout_hit) begin
        seen_mask_reg  <= '0;
      end
      // An illegal capture freezes the timeout counter for that cycle.
      if (legal_cap) begin
        to_cnt_reg <= '0;
        stale      <= 1'b0;
      end else if (!capture && to_cnt_reg != TO_LAST) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
        if (timeout_hit) begin
          stale <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random dwells scored against a run-length model.
module tb_seg_scan_decoder;

  localparam int N = 4;
  localparam int T = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  led_bit = 4'hF;
  logic [7:0]  led_out = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        frame_valid, value_changed, seg_err, stale;

  seg_scan_decoder #(.STABLE_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .led_bit(led_bit), .led_out(led_out),
    .digits(digits), .dp(dp), .frame_valid(frame_valid), .value_changed(value_changed),
    .seg_err(seg_err), .stale(stale)
  );

  always #5 sys_clk = ~sys_clk;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0, drv_cyc = 0, scan_start = 0, frame_cyc = 0;
  int obs_frames = 0, obs_err = 0, exp_err = 0;
  logic [15:0] last_digits = '0;
  logic [3:0]  last_dp = '0;
  logic        last_vc = 1'b0;

  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0]  ill_tab [4]  = '{7'h7F, 7'h01, 7'h55, 7'h3F};

  // Reference model: per-pin-cycle run length; a run of N identical samples with one digit selected is one capture.
  int          m_run;
  logic [11:0] m_prev;
  logic [3:0]  m_seen;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp;
  logic [19:0] m_last;
  logic [20:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sel_pos(input logic [3:0] bits);
    int p = -1;
    int z = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bits[i]) begin
        z++;
        p = i;
      end
    end
    return (z == 1) ? p : -1;
  endfunction

  function automatic int seg_digit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) begin
      if (seg_tab[d] == s) return d;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_prev = '0;
    m_seen = '0;
    m_dp   = '0;
    m_last = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
  endtask

  task automatic model_step(input logic [3:0] bits, input logic [7:0] seg);
    logic [11:0] v;
    logic [19:0] fr;
    int p, d;
    v = {bits, seg};
    if (v == m_prev) m_run++;
    else m_run = 1;
    m_prev = v;
    p = sel_pos(bits);
    if (m_run == N && p >= 0) begin
      d = seg_digit(seg[6:0]);
      if (d < 0) begin
        exp_err++;
      end else begin
        m_dig[p]  = 4'(d);
        m_dp[p]   = ~seg[7];
        m_seen[p] = 1'b1;
        if (m_seen == 4'hF) begin
          fr = {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp};
          exp_q.push_back({(fr != m_last), fr});
          m_last = fr;
          m_seen = '0;
        end
      end
    end
  endtask

  task automatic drive_cycle(input logic [3:0] bits, input logic [7:0] seg);
    @(negedge sys_clk);
    led_bit = bits;
    led_out = seg;
    drv_cyc = cyc;
    model_step(bits, seg);
  endtask

  task automatic dwell(input logic [3:0] bits, input logic [7:0] seg, input int len);
    drive_cycle(bits, seg);
    scan_start = drv_cyc;
    for (int i = 1; i < len; i++) drive_cycle(bits, seg);
  endtask

  task automatic scan(input int pos, input logic [7:0] seg, input int len);
    logic [3:0] b;
    b = 4'hF;
    b[pos] = 1'b0;
    dwell(b, seg, len);
  endtask

  task automatic ghost_scan(input int pos, input logic [7:0] ghost, input logic [7:0] seg);
    logic [3:0] b;
    b = 4'hF;
    b[pos] = 1'b0;
    drive_cycle(b, ghost);
    drive_cycle(b, ghost);
    dwell(b, seg, 20);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) drive_cycle(4'hF, 8'hFF);
  endtask

  task automatic do_reset(input int n, input bit rand_pins);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    if (rand_pins) begin
      led_bit = 4'($urandom);
      led_out = 8'($urandom);
    end
    for (int i = 0; i < n; i++) @(negedge sys_clk);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_value_changed", 32'(value_changed), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    led_bit = 4'hF;
    led_out = 8'hFF;
    sys_rst = 1'b0;
    model_reset();
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial begin : monitor
    logic [20:0] e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        if (seg_err) obs_err++;
        if (frame_valid) begin
          obs_frames++;
          frame_cyc   = cyc;
          last_digits = digits;
          last_dp     = dp;
          last_vc     = value_changed;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 32'(frame_valid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("frame_digits", 32'(digits), 32'(e[19:4]));
            check("frame_dp", 32'(dp), 32'(e[3:0]));
            check("frame_vc", 32'(value_changed), 32'(e[20]));
          end
        end
      end
    end
  end

  initial begin : main
    int f0, e0, since, kind, len, p;
    logic [3:0]  b;
    logic [7:0]  s;
    logic [11:0] last_v;

    model_reset();

    // Reset with random pins, then quiet window
    do_reset(3, 1'b1);
    flush(10);
    check("post_rst_frames", 32'(obs_frames), 32'h0);
    check("post_rst_seg_err", 32'(obs_err), 32'h0);

    // Basic frame and repeated identical frame
    f0 = obs_frames;
    scan(0, 8'hC0, 20); scan(1, 8'h92, 20); scan(2, 8'h30, 20); scan(3, 8'hF9, 20);
    flush(10);
    check("basic_frames", 32'(obs_frames - f0), 32'd1);
    check("basic_digits", 32'(last_digits), 32'h1350);
    check("basic_dp", 32'(last_dp), 32'h4);
    check("basic_vc", 32'(last_vc), 32'h1);
    check("basic_latency", 32'(frame_cyc - scan_start), 32'd6);
    f0 = obs_frames;
    scan(0, 8'hC0, 20); scan(1, 8'h92, 20); scan(2, 8'h30, 20); scan(3, 8'hF9, 20);
    flush(10);
    check("repeat_frames", 32'(obs_frames - f0), 32'd1);
    check("repeat_digits", 32'(last_digits), 32'h1350);
    check("repeat_vc", 32'(last_vc), 32'h0);

    // Ghosting at each select change
    f0 = obs_frames;
    e0 = obs_err;
    ghost_scan(0, 8'hF9, 8'hF8); ghost_scan(1, 8'hF9, 8'h90);
    ghost_scan(2, 8'hF9, 8'hA4); ghost_scan(3, 8'hF9, 8'h80);
    flush(10);
    check("ghost_frames", 32'(obs_frames - f0), 32'd1);
    check("ghost_digits", 32'(last_digits), 32'h8297);
    check("ghost_dp", 32'(last_dp), 32'h0);
    check("ghost_vc", 32'(last_vc), 32'h1);
    check("ghost_latency", 32'(frame_cyc - scan_start), 32'd6);
    check("ghost_seg_err", 32'(obs_err - e0), 32'd0);

    // Illegal pattern on position 1
    f0 = obs_frames;
    e0 = obs_err;
    scan(0, 8'hC0, 20); scan(1, 8'hFF, 20);
    flush(10);
    check("illegal_seg_err", 32'(obs_err - e0), 32'd1);
    scan(2, 8'hC0, 20); scan(3, 8'hC0, 20);
    flush(10);
    check("illegal_no_frame", 32'(obs_frames - f0), 32'd0);
    scan(1, 8'hF9, 20);
    flush(10);
    check("illegal_frames", 32'(obs_frames - f0), 32'd1);
    check("illegal_digits", 32'(last_digits), 32'h0010);
    check("illegal_seg_err_total", 32'(obs_err - e0), 32'd1);

    // Bad select and timeout
    f0 = obs_frames;
    e0 = obs_err;
    dwell(4'b1100, 8'hC0, 20);
    check("bad_sel_not_stale", 32'(stale), 32'h0);
    dwell(4'b1100, 8'hC0, 30);
    dwell(4'b1111, 8'hC0, 50);
    check("bad_sel_stale", 32'(stale), 32'h1);
    check("bad_sel_digits_held", 32'(digits), 32'h0010);
    check("bad_sel_frames", 32'(obs_frames - f0), 32'd0);
    check("bad_sel_seg_err", 32'(obs_err - e0), 32'd0);
    scan(0, 8'hC0, 20);
    check("stale_cleared", 32'(stale), 32'h0);

    // Mid-frame reset discards partial captures
    scan(1, 8'hA4, 20); scan(2, 8'hB0, 20);
    do_reset(2, 1'b0);
    f0 = obs_frames;
    scan(3, 8'h99, 20);
    flush(10);
    check("midrst_no_frame", 32'(obs_frames - f0), 32'd0);
    scan(0, 8'hC0, 20); scan(1, 8'hA4, 20); scan(2, 8'hB0, 20); scan(3, 8'h99, 20);
    flush(10);
    check("midrst_frames", 32'(obs_frames - f0), 32'd1);
    check("midrst_digits", 32'(last_digits), 32'h4320);
    check("midrst_vc", 32'(last_vc), 32'h1);

    // Random dwells; legal dwells are forced often enough that the timeout never fires
    since  = 30;
    last_v = {led_bit, led_out};
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 9);
      if (since > 42) kind = 0;
      do begin
        p = $urandom_range(0, 3);
        b = 4'hF;
        b[p] = 1'b0;
        if (kind < 5) begin
          s   = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 9)]};
          len = $urandom_range(N, 12);
        end else if (kind < 7) begin
          s   = 8'($urandom);
          len = $urandom_range(1, N - 1);
        end else if (kind == 7) begin
          s   = {1'($urandom_range(0, 1)), ill_tab[$urandom_range(0, 3)]};
          len = $urandom_range(N, 8);
        end else begin
          do b = 4'($urandom); while (sel_pos(b) >= 0);
          s   = 8'($urandom);
          len = $urandom_range(1, 8);
        end
      end while ({b, s} == last_v);
      dwell(b, s, len);
      last_v = {b, s};
      if (kind < 5) since = len;
      else since += len;
    end
    flush(12);
    check("rand_frames_pending", 32'(exp_q.size()), 32'd0);
    check("rand_seg_err_total", 32'(obs_err), 32'(exp_err));
    check("rand_not_stale", 32'(stale), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart to the stopwatch's multiplexed 4-digit 7-segment display drive.
- Samples the active-low digit-select and segment buses, waits for each digit's pattern to settle, and decodes it back to BCD digits plus decimal points.
- Publishes a full 4-digit frame once every digit position has been captured.
- Used as an on-board display monitor and as a self-check/scoreboard front end in system benches.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured; minimum 2.
- TIMEOUT_CYCLES, 50000: cycles without any capture before stale asserts.
- Counter widths are $clog2(param+1).

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  reset, asynchronous and active-high; one clock.
- led_bit  input  4  digit select, active-low; bit0 = seconds-low … bit3 = minutes-high.
- led_out  input  8  segments, active-low; [6:0] = g..a, [7] = dp.
- digits  output  16  BCD; [3:0] = position 0 … [15:12] = position 3.
- dp  output  4  decimal point per position, 1 = lit.
- frame_valid  output  1  1-cycle pulse; digits/dp updated this cycle.
- value_changed  output  1  1-cycle pulse with frame_valid when {digits,dp} differ from the previous frame.
- seg_err  output  1  1-cycle pulse: a settled pattern is not a legal digit.
- stale  output  1  level; no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset:
  - All outputs 0.
  - Synchronizers, stability counter, seen_mask, timeout counter and last-frame register all 0.
  - Reset mid-dwell or mid-frame discards partial captures.
- Input sync: 2-flop synchronizer on {led_bit, led_out}; all logic uses the synced value S.
- Valid select: S.led_bit has exactly one 0 bit (idx = that position). 4'b1111 or multiple zeros = no select.
- FSM states:
  - IDLE: no valid select. Go to SETTLE when a valid select appears (stab_cnt = 1).
  - SETTLE: stab_cnt increments each cycle S equals the previous S. Any change returns to stab_cnt = 1, or to IDLE if the select becomes invalid. When stab_cnt reaches STABLE_CYCLES, capture and go to HOLD.
  - HOLD: no further capture while S is unchanged. Any change goes to SETTLE (stab_cnt = 1) or IDLE.
- Exactly one capture per dwell, regardless of dwell length.
- Decode of led_out[6:0]: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9 (hex, 7-bit). led_out[7] is ignored for the digit value.
- Legal capture:
  - digit_reg[idx] ← value; dp_reg[idx] ← ~led_out[7]; seen_mask[idx] ← 1.
  - Timeout counter clears; stale clears.
  - Recapturing a position already in seen_mask overwrites it.
- Illegal pattern at capture:
  - seg_err pulses the same cycle.
  - digit_reg, seen_mask and the timeout counter are unchanged.
- Frame publish:
  - Triggered when seen_mask including the current capture is 4'b1111.
  - Next cycle: digits/dp ← registers, frame_valid = 1, value_changed = ({digit_reg,dp_reg} != last frame).
  - Same cycle: last frame updated and seen_mask cleared.
  - A capture coincident with a publish starts the next frame's seen_mask.
- Latency: select/segment edge at pins → capture = 2 + STABLE_CYCLES − 1 cycles; capture → frame_valid = 1 cycle.
- Timeout:
  - Counter increments every cycle without a legal capture and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: stale ← 1 and seen_mask cleared.
  - stale holds until the next legal capture.
  - digits/dp hold their last published values.
- Glitch immunity: any dwell shorter than STABLE_CYCLES samples causes no capture, no seg_err and no state change beyond FSM/stab_cnt.

Test Plan (STABLE_CYCLES = 4, TIMEOUT_CYCLES = 64):
- Reset: hold sys_rst 3 cycles with random inputs → all outputs 0; no pulse for 10 cycles after release.
- Basic frame: scan positions 0..3 with C0,92,30,F9, 20 cycles each → one frame_valid, digits = 16'h1350, dp = 4'b0100, value_changed = 1; a repeated identical scan gives frame_valid with value_changed = 0.
- Ghosting: 2-cycle wrong pattern (F9) at each select change before the correct one → digits unaffected; capture occurs 4 settled samples after the correct value appears.
- Illegal: position 1 held at 8'hFF for 20 cycles → exactly one seg_err pulse; no frame until position 1 later shows a legal digit.
- Bad select: led_bit = 4'b1100 or 4'b1111 for 50 cycles → no capture, no seg_err; stale asserts at cycle 64 of no capture, then clears on the next legal capture.
- Mid-frame reset: capture positions 0–2, assert sys_rst, then scan position 3 only → no frame_valid until all four positions are recaptured.
